// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end
// (pc_fetch_unit and its output buffer).
package pc_fetch_unit_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK       = ~(INSTR_BYTES - 32'd1);
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_out_buf.sv
// One-entry valid/ready holding register between fetch and decode.
// Optional macro PC_MISALIGN_CHECK_EN adds a misaligned-target flag.
module fetch_out_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
`ifdef PC_MISALIGN_CHECK_EN
    input  logic            load_misalign,
    output logic            if_misalign,
`endif
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus_4
);
    import pc_fetch_unit_pkg::*;

    // Clear beats load beats handshake: a redirect squashes whatever is here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid     <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
            if_pc_plus_4 <= '0;
`ifdef PC_MISALIGN_CHECK_EN
            if_misalign  <= 1'b0;
`endif
        end else if (clear) begin
            if_valid     <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
            if_misalign  <= 1'b0;
`endif
        end else if (load) begin
            if_valid     <= 1'b1;
            if_instr     <= load_instr;
            if_pc        <= load_pc;
            if_pc_plus_4 <= load_pc + INSTR_BYTES;
`ifdef PC_MISALIGN_CHECK_EN
            if_misalign  <= load_misalign;
`endif
        end else if (if_valid && if_ready) begin
            if_valid     <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
            if_misalign  <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests, feeds decode.
// Optional macro PC_MISALIGN_CHECK_EN reports misaligned redirects via if_misalign.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = pc_fetch_unit_pkg::DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus_4
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic            if_misalign
`endif
);
    import pc_fetch_unit_pkg::*;

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            req_fire;
    logic            out_blocked;
    logic            buf_clear;
    logic            buf_load;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] buf_pc;
`ifdef PC_MISALIGN_CHECK_EN
    logic            buf_misalign;
    logic            redirect_misaligned;
    logic            rsp_pending;

    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    assign rsp_pending         = ((state == WAIT) || (state == DRAIN)) && !imem_rsp_valid;
`endif

    assign imem_req_valid = rst_n && (state == REQ) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_blocked    = if_valid && !if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        buf_instr = imem_rsp_data;
        buf_pc    = pc;
`ifdef PC_MISALIGN_CHECK_EN
        buf_misalign = 1'b0;
`endif
        unique case (state)
            REQ: begin
                if (req_fire) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    // A stalled entry cannot be overwritten: drop the word and
                    // refetch the same pc once decode has taken the entry.
                    if (out_blocked) begin
                        state_nxt = HOLD;
                    end else begin
                        buf_load  = 1'b1;
                        pc_nxt    = pc + INSTR_BYTES;
                        state_nxt = if_ready ? REQ : HOLD;
                    end
                end
            end
            HOLD: begin
                if (if_valid && if_ready) state_nxt = REQ;
            end
            DRAIN: begin
                if (imem_rsp_valid) state_nxt = out_blocked ? HOLD : REQ;
            end
        endcase

        if (redirect_valid) begin
            buf_load  = 1'b0;
            buf_clear = 1'b1;
            pc_nxt    = redirect_pc & ALIGN_MASK;
            if ((state == WAIT) || (state == DRAIN))
                state_nxt = imem_rsp_valid ? REQ : DRAIN;
            else
                state_nxt = REQ;
`ifdef PC_MISALIGN_CHECK_EN
            if (redirect_misaligned) begin
                buf_clear    = 1'b0;
                buf_load     = 1'b1;
                buf_instr    = '0;
                buf_pc       = redirect_pc;
                buf_misalign = 1'b1;
                state_nxt    = rsp_pending ? DRAIN : HOLD;
            end
`endif
        end
    end

    fetch_out_buf #(
        .XLEN(XLEN)
    ) u_out_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (buf_clear),
        .load         (buf_load),
        .load_instr   (buf_instr),
        .load_pc      (buf_pc),
`ifdef PC_MISALIGN_CHECK_EN
        .load_misalign(buf_misalign),
        .if_misalign  (if_misalign),
`endif
        .if_ready     (if_ready),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus_4 (if_pc_plus_4)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: memory model, program-order reference queue,
// directed timing checks and a randomized redirect/stall phase.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
`ifdef PC_MISALIGN_CHECK_EN
    logic        if_misalign;
`endif

    pc_fetch_unit #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus_4  (if_pc_plus_4)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .if_misalign   (if_misalign)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned commit_cnt = 0;

    // Reference model: the program-order stream of pcs decode should commit.
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;

    int unsigned lat_min = 0, lat_max = 0, ready_pct = 100;
    bit          mem_busy = 1'b0;
    bit          mem_was_busy;
    logic [31:0] mem_addr;
    int unsigned mem_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        exp_q.delete();
        exp_tail = t & 32'hFFFF_FFFC;
        exp_q.push_back(exp_tail);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_tail = RST_PC;
        exp_q.push_back(RST_PC);
    endtask

    task automatic wait_req_fire(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid && imem_req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_if_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // Memory: one pulse per accepted request after a programmable latency.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_req_ready = ($urandom_range(0, 99) < ready_pct);
            imem_rsp_valid = mem_busy && (mem_cnt == 0);
            imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
            #2;
            if (!rst_n) begin
                mem_busy = 1'b0;
            end else begin
                mem_was_busy = mem_busy;
                if (imem_rsp_valid) mem_busy = 1'b0;
                else if (mem_busy) mem_cnt--;
                if (imem_req_valid && imem_req_ready) begin
                    check("single_outstanding", {31'd0, mem_was_busy}, 32'd0);
                    mem_busy = 1'b1;
                    mem_addr = imem_req_addr;
                    mem_cnt  = $urandom_range(lat_min, lat_max);
                end
            end
        end
    end

    // Monitor: compares every committed decode handshake against the queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk); #3;
            if (rst_n) begin
                if (redirect_valid) check("no_req_in_redirect", {31'd0, imem_req_valid}, 32'd0);
                if (if_valid && if_ready && !redirect_valid) begin
                    while (exp_q.size() < 4) begin
                        exp_tail = exp_tail + 32'd4;
                        exp_q.push_back(exp_tail);
                    end
                    e = exp_q.pop_front();
                    check("commit_pc", if_pc, e);
                    check("commit_instr", if_instr, mem_word(e));
                    check("commit_pc_plus_4", if_pc_plus_4, e + 32'd4);
                    commit_cnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  e_hold;
        int unsigned  c0;
        logic [31:0]  t;
        bit           found;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_pc_plus_4", if_pc_plus_4, 32'd0);

        // Zero-wait fetch from a reset vector that wraps; one commit per 2 cycles
        @(negedge clk); rst_n = 1'b1; #1;
        check("t1_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t1_first_req_addr", imem_req_addr, RST_PC);
        c0 = commit_cnt;
        repeat (10) @(negedge clk);
        check("t1_throughput", commit_cnt - c0, 32'd4);

        // Decode stall holds the buffered entry and blocks new requests
        if_ready = 1'b0;
        wait_if_valid("t2_wait_valid");
        repeat (2) @(negedge clk);
        #1;
        e_hold = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t2_stall_pc", if_pc, e_hold);
            check("t2_stall_instr", if_instr, mem_word(e_hold));
            check("t2_stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        @(negedge clk); if_ready = 1'b1; #1;
        check("t2_release_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk); #1;
        check("t2_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t2_next_req_addr", imem_req_addr, e_hold + 32'd4);

        // Redirect in REQ suppresses that cycle's request
        wait_req_fire("t5_wait_req");
        @(negedge clk);
        @(negedge clk); do_redirect(32'h40); #1;
        check("t5_no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("t5_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t5_req_addr", imem_req_addr, 32'h40);

        // Redirect while HOLD clears the buffer
        if_ready = 1'b0;
        wait_if_valid("t5_hold_wait_valid");
        repeat (2) @(negedge clk);
        @(negedge clk); do_redirect(32'h80);
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("t5_hold_if_valid", {31'd0, if_valid}, 32'd0);
        check("t5_hold_req_addr", imem_req_addr, 32'h80);
        check("t5_hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
        @(negedge clk); if_ready = 1'b1;

        // Redirect coinciding with the response drops the data
        wait_req_fire("t4_wait_req");
        @(negedge clk); do_redirect(32'h200);
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("t4_if_valid", {31'd0, if_valid}, 32'd0);
        check("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h200);

        // Redirect in WAIT, response 3 cycles later is drained
        lat_min = 3; lat_max = 3;
        wait_req_fire("t3_wait_req");
        @(negedge clk); do_redirect(32'h100);
        found = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) redirect_valid = 1'b0;
            #1;
            if (imem_req_valid) begin
                found = 1'b1;
                check("t3_req_addr", imem_req_addr, 32'h100);
                check("t3_req_delay", i, 32'd4);
                break;
            end
            check("t3_if_valid_low", {31'd0, if_valid}, 32'd0);
        end
        check("t3_req_seen", {31'd0, found}, 32'd1);
        lat_min = 0; lat_max = 0;

`ifdef PC_MISALIGN_CHECK_EN
        // Misaligned target is reported, not fetched
        @(negedge clk); if_ready = 1'b0; do_redirect(32'h102);
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("t6_mis_valid", {31'd0, if_valid}, 32'd1);
        check("t6_mis_flag", {31'd0, if_misalign}, 32'd1);
        check("t6_mis_pc", if_pc, 32'h102);
        check("t6_mis_instr", if_instr, 32'd0);
        check("t6_mis_no_req", {31'd0, imem_req_valid}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("t6_mis_hold_valid", {31'd0, if_valid}, 32'd1);
        check("t6_mis_hold_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk); do_redirect(32'h300); if_ready = 1'b1;
        @(negedge clk); redirect_valid = 1'b0;
`else
        // Low bits of a redirect target are ignored
        @(negedge clk); do_redirect(32'h103);
        found = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) redirect_valid = 1'b0;
            #1;
            if (imem_req_valid) begin
                found = 1'b1;
                check("t6_align_req_addr", imem_req_addr, 32'h100);
                break;
            end
        end
        check("t6_align_req_seen", {31'd0, found}, 32'd1);
`endif

        // Randomized redirects, stalls and memory latency
        lat_min = 0; lat_max = 3; ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if_ready = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 5) begin
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
                else t = $urandom_range(0, 255) << 2;
`ifndef PC_MISALIGN_CHECK_EN
                t = t | $urandom_range(0, 3);
`endif
                do_redirect(t);
            end else begin
                redirect_valid = 1'b0;
            end
        end

        // Reset mid-operation
        @(negedge clk); redirect_valid = 1'b0; rst_n = 1'b0; #1;
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mid_rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("mid_rst_if_pc", if_pc, 32'd0);
        repeat (2) @(negedge clk);
        model_reset();
        @(negedge clk); rst_n = 1'b1; if_ready = 1'b1; #1;
        check("mid_rst_req_addr", imem_req_addr, RST_PC);
        check("mid_rst_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
        c0 = commit_cnt;
        repeat (40) @(negedge clk);
        check("post_rst_progress", {31'd0, (commit_cnt - c0) >= 5}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
